// File: rtl/counter_driver_pkg.sv
// Shared types and constants for the counter driver.
package counter_driver_pkg;
    localparam int COUNTER_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/counter_driver.sv
// Drives a counter through an external add stage for a programmed number of
// updates, checking each returned value for wrap and for deviation from +STEP.
module counter_driver
    import counter_driver_pkg::*;
#(
    parameter int STEP = 2
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [COUNTER_W-1:0] init_value,
    input  logic [COUNTER_W-1:0] iterations,
    input  logic                 hold,
    input  logic [COUNTER_W-1:0] tock_ret,
    output logic [COUNTER_W-1:0] tock_old_counter,
    output logic                 busy,
    output logic                 done,
    output logic [COUNTER_W-1:0] iter_count,
    output logic                 wrapped,
    output logic                 mismatch
);
    localparam logic [COUNTER_W-1:0] STEP_W = COUNTER_W'(STEP);

    state_t               state;
    logic [COUNTER_W-1:0] iters_q;
    logic [COUNTER_W-1:0] iter_next;
    logic [COUNTER_W-1:0] expected;

    assign iter_next = iter_count + 8'd1;
    assign expected  = tock_old_counter + STEP_W;

    // busy/done are registered alongside state so no input reaches them combinationally.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            tock_old_counter <= '0;
            iters_q          <= '0;
            iter_count       <= '0;
            wrapped          <= 1'b0;
            mismatch         <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        tock_old_counter <= init_value;
                        iters_q          <= iterations;
                        iter_count       <= '0;
                        wrapped          <= 1'b0;
                        mismatch         <= 1'b0;
                        if (iterations == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!hold) begin
                        tock_old_counter <= tock_ret;
                        iter_count       <= iter_next;
                        if (tock_ret < tock_old_counter) wrapped  <= 1'b1;
                        if (tock_ret != expected)        mismatch <= 1'b1;
                        if (iter_next == iters_q) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_counter_driver.sv
// Randomized bench for counter_driver with a run-level reference model.
module tb_counter_driver;
    localparam int STEP = 2;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       hold  = 1'b0;
    logic [7:0] init_value = '0;
    logic [7:0] iterations = '0;
    logic [7:0] bias = '0;
    logic [7:0] tock_ret;
    logic [7:0] tock_old_counter;
    logic [7:0] iter_count;
    logic       busy, done, wrapped, mismatch;

    int n_vec = 0;
    int n_err = 0;

    // Downstream add stage; bias injects deliberate errors.
    assign tock_ret = tock_old_counter + 8'(STEP) + bias;

    counter_driver #(.STEP(STEP)) dut (
        .clock(clock), .rst_n(rst_n), .start(start), .init_value(init_value),
        .iterations(iterations), .hold(hold), .tock_ret(tock_ret),
        .tock_old_counter(tock_old_counter), .busy(busy), .done(done),
        .iter_count(iter_count), .wrapped(wrapped), .mismatch(mismatch)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cnt"},  tock_old_counter, 0);
        chk({tag, "_iter"}, iter_count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_wrap"}, wrapped, 0);
        chk({tag, "_mis"},  mismatch, 0);
    endtask

    // One run: model tracks the expected counter sequence and sticky flags.
    task automatic do_run(input logic [7:0] init, input int n, input int hold_first,
                          input int hold_pct, input int err_pct, input int first_bias,
                          input bit keep_start, input bit pre, input int abort_at);
        logic [7:0] m_cnt;
        logic [7:0] nv;
        int k, cyc, held;
        bit m_wrap, m_mis;
        m_cnt = init; k = 0; cyc = 0; held = 0; m_wrap = 0; m_mis = 0;
        if (!pre) begin
            @(negedge clock);
            start = 1'b1; init_value = init; iterations = 8'(n);
        end
        hold = 1'b0; bias = '0;
        @(posedge clock); #1;
        chk("acc_cnt", tock_old_counter, init);
        chk("acc_busy", busy, n != 0);
        chk("acc_done", done, n == 0);
        chk("acc_iter", iter_count, 0);
        chk("acc_wrap", wrapped, 0);
        chk("acc_mis", mismatch, 0);
        while (k < n) begin
            @(negedge clock);
            start = keep_start;
            if (keep_start) begin
                init_value = 8'h77; iterations = 8'd1;
            end else begin
                init_value = 8'($urandom); iterations = 8'($urandom);
            end
            if (abort_at >= 0 && k == abort_at) begin
                rst_n = 1'b0; start = 1'b0; hold = 1'b0; bias = '0;
                #1 chk_all_zero("rst_mid");
                @(negedge clock);
                rst_n = 1'b1;
                repeat (3) begin
                    @(posedge clock); #1;
                    chk("rst_no_done", done, 0);
                    chk("rst_no_busy", busy, 0);
                end
                return;
            end
            hold = (held < hold_first) || ($urandom_range(99) < hold_pct);
            held++;
            if (first_bias >= 0 && k == 0) bias = 8'(first_bias);
            else if ($urandom_range(99) < err_pct) bias = 8'($urandom_range(1, 255));
            else bias = '0;
            if (!hold) begin
                nv = m_cnt + 8'(STEP) + bias;
                if (nv < m_cnt) m_wrap = 1;
                if (bias != 0) m_mis = 1;
                m_cnt = nv;
                k++;
            end
            @(posedge clock); #1;
            chk("run_cnt", tock_old_counter, m_cnt);
            chk("run_iter", iter_count, k);
            chk("run_wrap", wrapped, m_wrap);
            chk("run_mis", mismatch, m_mis);
            chk("run_busy", busy, k < n);
            chk("run_done", done, k == n);
            cyc++;
            if (cyc > 4 * n + hold_first + 64) begin
                chk("timeout", 1, 0);
                return;
            end
        end
        @(negedge clock);
        start = keep_start; hold = 1'b0; bias = '0;
        @(posedge clock); #1;
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_cnt", tock_old_counter, m_cnt);
        chk("post_iter", iter_count, k);
        chk("post_wrap", wrapped, m_wrap);
        chk("post_mis", mismatch, m_mis);
    endtask

    initial begin
        #2 chk_all_zero("reset");
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        @(posedge clock); #1 chk_all_zero("idle");

        do_run(8'd10, 3, 0, 0, 0, -1, 0, 0, -1);          // normal run
        do_run(8'hFE, 2, 0, 0, 0, -1, 0, 0, -1);          // wrap-around
        do_run(8'h55, 0, 0, 0, 0, -1, 0, 0, -1);          // zero iterations
        do_run(8'd4, 2, 3, 0, 0, 3, 0, 0, -1);            // hold then ret=9
        do_run(8'd0, 10, 0, 0, 0, -1, 0, 0, 4);           // reset after 4 updates
        do_run(8'd1, 1, 0, 0, 0, -1, 0, 0, -1);           // fresh run after reset
        do_run(8'h20, 3, 0, 0, 0, -1, 1, 0, -1);          // start held high
        do_run(8'h77, 1, 0, 0, 0, -1, 0, 1, -1);          // accepted right after DONE
        do_run(8'hF0, 255, 0, 10, 5, -1, 0, 0, -1);       // full-range iteration count
        for (int i = 0; i < 12; i++)
            do_run(8'($urandom), $urandom_range(0, 6), 0, 30, 20, -1, 0, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, vectors %0d", n_vec);
        $fatal(1);
    end
endmodule

// File: doc/counter_driver.md
COUNTER_DRIVER -- requirements
Module: counter_driver

Interface
REQ-001 SHALL have parameter STEP, default 2: expected increment applied by the downstream add stage, used by the result checker.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-005 SHALL have port init_value  input  8  counter value loaded on accepted start.
REQ-006 SHALL have port iterations  input  8  number of counter updates per run, captured on accepted start.
REQ-007 SHALL have port hold  input  1  stall; suppresses the update in RUN.
REQ-008 SHALL have port tock_ret  input  8  result returned combinationally by the downstream add stage.
REQ-009 SHALL have port tock_old_counter  output  8  current counter register, driven to the downstream add stage.
REQ-010 SHALL have port busy  output  1  high in RUN.
REQ-011 SHALL have port done  output  1  one-cycle pulse, high only in DONE.
REQ-012 SHALL have port iter_count  output  8  updates completed in the current or last run.
REQ-013 SHALL have port wrapped  output  1  sticky; an update produced a value below the previous counter.
REQ-014 SHALL have port mismatch  output  1  sticky; tock_ret differed from the expected value on an update.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 In IDLE with start=1: load counter=init_value, capture iterations, clear iter_count, wrapped and mismatch; go to DONE if iterations==0, else go to RUN.
REQ-017 In IDLE with start=0: hold all registers.
REQ-018 In RUN with hold=1: hold all registers and stay in RUN.
REQ-019 In RUN with hold=0 (an update): counter<=tock_ret and iter_count<=iter_count+1; go to DONE when iter_count+1 equals the captured iterations, else stay in RUN.
REQ-020 On an update, SHALL set wrapped if tock_ret < counter (unsigned).
REQ-021 On an update, SHALL set mismatch if tock_ret != (counter+STEP) mod 256.
REQ-022 Flag setting SHALL be independent: both flags MAY set on the same update.
REQ-023 DONE SHALL last exactly one cycle, then go to IDLE; start in DONE SHALL be ignored.
REQ-024 start in RUN SHALL be ignored; changes to init_value and iterations after capture SHALL have no effect until the next accepted start.
REQ-025 All arithmetic SHALL be 8-bit modulo 256; iter_count SHALL never exceed the captured iterations.
REQ-026 tock_old_counter, busy and done SHALL be pure functions of registered state; no combinational path from tock_ret to any output.

Reset
REQ-027 rst_n low SHALL asynchronously force: state=IDLE, counter=0, iter_count=0, wrapped=0, mismatch=0, busy=0, done=0.
REQ-028 Reset asserted mid-run SHALL abort the run with no done pulse; the first accepted start after rst_n rises SHALL behave as from power-up.

Structure
REQ-029 A shared package counter_driver_pkg SHALL hold the state enum typedef and constant COUNTER_W=8.
REQ-030 No sub-module SHALL be used; the FSM, counter and checker SHALL be a single module.

Verification
REQ-031 Normal run: init_value=10, iterations=3, bench returns old+2 -> tock_old_counter 10,12,14,16 on successive cycles; done pulses once with iter_count=3; wrapped=0, mismatch=0.
REQ-032 Wrap-around: init_value=0xFE, iterations=2 -> counter 0x00 then 0x02; wrapped=1; mismatch=0.
REQ-033 Zero iterations: init_value=0x55, iterations=0 -> DONE on the cycle after start; counter=0x55; iter_count=0; busy never high.
REQ-034 Hold and mismatch: init_value=4, iterations=2, hold=1 for 3 cycles after start, then bench returns 9 -> counter unchanged during hold; counter=9 and mismatch=1 after the first update.
REQ-035 Reset mid-run: init_value=0, iterations=10, rst_n pulsed low after 4 updates -> all outputs 0 and state IDLE immediately; no done pulse; a new start with init_value=1, iterations=1 gives counter 3 and one done pulse.
REQ-036 Ignored start: start held high throughout a 3-iteration run -> no reload during RUN or DONE; a new run is accepted only on the cycle after DONE.
